ss_fifo_sync_fwft: RTL
======================

Name: ss_fifo_sync_fwft

Overview:
Parametrised synchronous FIFO, successor to the basic ss_fifo_sync buffer used in the converter path.
- Depth may be any value up to 2^Bw_a, not only a power of two.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Exact full/empty flags, an occupancy count, threshold ready flags, and sticky overflow/underflow error flags.
- Sits between the bit-sparsity converter stages as an elastic buffer.

Parameters:
Bw_d, 8, data width in bits.
Bw_a, 10, address width; pointers are Bw_a bits, count is Bw_a+1 bits.
Depth, 1<<Bw_a, number of storage words; legal range 2 .. 2^Bw_a.
FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.
Thrs_wr, Depth/4*3, wr_rdy asserted while count <= Thrs_wr.
Thrs_rd, Depth/4, rd_rdy asserted while count >= Thrs_rd.

Ports:
clk  input  1  clock, all logic on rising edge.
reset_n  input  1  synchronous reset, active low.
wr_di  input  Bw_d  write data.
wr_en  input  1  write request.
rd_en  input  1  read request (standard mode) / pop acknowledge (FWFT mode).
wr_rdy  output  1  threshold write-ready (count <= Thrs_wr).
rd_rdy  output  1  threshold read-ready (count >= Thrs_rd).
full  output  1  count == Depth.
empty  output  1  count == 0.
count  output  Bw_a+1  words held, 0..Depth.
rd_do  output  Bw_d  read data.
rd_vld  output  1  rd_do carries valid data this cycle.
ovf  output  1  sticky: a write was attempted while full.
udf  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (reset_n == 0 at a rising edge):
  - Clears write/read pointers, count, rd_do, rd_vld, ovf and udf.
  - After reset: empty=1, full=0, wr_rdy=1, rd_rdy=(Thrs_rd==0).
  - Reset mid-operation discards all contents; memory array contents are not cleared.
- Write acceptance: wr_acc = wr_en & ~full.
  - An accepted write stores wr_di at wr_ptr.
  - wr_ptr wraps from Depth-1 to 0 explicitly; no power-of-two masking.
- Read acceptance: rd_acc = rd_en & ~empty.
  - An accepted read advances rd_ptr, with the same wrap rule.
- Count update each cycle:
  - count += wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
- Full FIFO with both wr_en and rd_en: read accepted, write rejected (full is evaluated before the pop), and ovf is set.
- Empty FIFO with both wr_en and rd_en: write accepted, read rejected, and udf is set.
- ovf/udf: set on the offending cycle's edge and held until reset. A rejected request has no other effect.
- full, empty, wr_rdy, rd_rdy: combinational from the count register only; glitch-free relative to clk.
- FWFT=0 (standard mode):
  - rd_do <= mem[rd_ptr] on rd_acc, with 1-cycle latency.
  - rd_vld is a 1-cycle pulse in the cycle after rd_acc.
  - rd_do holds its last value otherwise.
- FWFT=1 (FWFT mode):
  - rd_do always presents the head word; rd_vld = ~empty.
  - A word written into an empty FIFO at edge t is visible with rd_vld=1 after edge t (next cycle).
  - rd_en is a pop of the presented word; the next word, if any, is presented after the same edge.
  - Back-to-back pops at one per cycle are sustained.
  - rd_do is don't-care when rd_vld=0.
- Throughput: one write and one read per cycle sustained in both modes.
- No combinational path from wr_en/rd_en to any output.

Test Plan:
1. Depth=6, Bw_a=3, FWFT=0: write 0x11..0x16 -> full=1, count=6; a 7th write -> ovf=1, count stays 6. Read 6 words -> rd_do = 0x11..0x16, each with a rd_vld pulse 1 cycle after rd_en; then empty=1.
2. Wrap, Depth=6: 20 interleaved write/read operations -> data order preserved across the 5→0 pointer wrap; count never exceeds 6.
3. FWFT=1: write 0xA5 into an empty FIFO -> next cycle rd_vld=1, rd_do=0xA5 with no rd_en. Pop -> rd_vld=0, empty=1.
4. Simultaneous operation at full: wr_en=rd_en=1 for 1 cycle -> count=Depth-1, ovf=1, oldest word popped. At empty, same stimulus -> count=1, udf=1.
5. Thresholds, Depth=16 (Thrs_wr=12, Thrs_rd=4): fill one word per cycle -> rd_rdy rises at count=4, wr_rdy falls at count=13; reverse on drain.
6. Reset mid-stream: reset_n=0 with count=5, ovf=1 -> next cycle count=0, empty=1, ovf=0, rd_vld=0; a following write/read returns the new data only.

Source files
------------

// File: rtl/ss_fifo_sync_fwft.sv
// Synchronous FIFO with arbitrary depth, standard or first-word-fall-through read,
// occupancy count, threshold ready flags and sticky overflow/underflow flags.
module ss_fifo_sync_fwft #(
  parameter int Bw_d    = 8,
  parameter int Bw_a    = 10,
  parameter int Depth   = 1 << Bw_a,
  parameter bit FWFT    = 1'b0,
  parameter int Thrs_wr = Depth / 4 * 3,
  parameter int Thrs_rd = Depth / 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [Bw_d-1:0] wr_di,
  input  logic            wr_en,
  input  logic            rd_en,
  output logic            wr_rdy,
  output logic            rd_rdy,
  output logic            full,
  output logic            empty,
  output logic [Bw_a:0]   count,
  output logic [Bw_d-1:0] rd_do,
  output logic            rd_vld,
  output logic            ovf,
  output logic            udf
);

  localparam logic [Bw_a:0]   DepthC   = (Bw_a + 1)'(Depth);
  localparam logic [Bw_a:0]   ThrsWrC  = (Bw_a + 1)'(Thrs_wr);
  localparam logic [Bw_a:0]   ThrsRdC  = (Bw_a + 1)'(Thrs_rd);
  localparam logic [Bw_a-1:0] LastPtrC = Bw_a'(Depth - 1);

  logic [Bw_d-1:0] mem [Depth];

  logic [Bw_a-1:0] wr_ptr_q, wr_ptr_d;
  logic [Bw_a-1:0] rd_ptr_q, rd_ptr_d;
  logic [Bw_a:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            full_w, empty_w;
  logic            wr_acc, rd_acc;

  // Status flags derive from the count register alone, so they never glitch on request inputs.
  assign full_w  = (count_q == DepthC);
  assign empty_w = (count_q == '0);
  assign wr_acc  = wr_en & ~full_w;
  assign rd_acc  = rd_en & ~empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_en & full_w);
    udf_d    = udf_q | (rd_en & empty_w);
    // Explicit wrap keeps non-power-of-two depths correct.
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LastPtrC) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LastPtrC) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset_n && wr_acc) begin
      mem[wr_ptr_q] <= wr_di;
    end
  end

  if (FWFT) begin : g_fwft
    assign rd_do  = mem[rd_ptr_q];
    assign rd_vld = ~empty_w;
  end else begin : g_std
    logic [Bw_d-1:0] rd_do_q, rd_do_d;
    logic            rd_vld_q, rd_vld_d;

    always_comb begin
      rd_do_d  = rd_do_q;
      rd_vld_d = rd_acc;
      if (rd_acc) begin
        rd_do_d = mem[rd_ptr_q];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rd_do_q  <= '0;
        rd_vld_q <= 1'b0;
      end else begin
        rd_do_q  <= rd_do_d;
        rd_vld_q <= rd_vld_d;
      end
    end

    assign rd_do  = rd_do_q;
    assign rd_vld = rd_vld_q;
  end

  assign full   = full_w;
  assign empty  = empty_w;
  assign count  = count_q;
  assign wr_rdy = (count_q <= ThrsWrC);
  assign rd_rdy = (count_q >= ThrsRdC);
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule
